// File: rtl/microwave_timer.sv
// M:SS countdown timer fed by the keypad timer controller: digits shift in on key
// ticks, then count down one second per tick while count_en is high.
// Optional macro PGT_SYNC_EN puts a 2-flop synchroniser on pgt_1Hz.
module microwave_timer (
    input  logic       clk_100Hz,
    input  logic       clear,
    input  logic [3:0] bcd,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       count_en,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic       zero,
    output logic       done
);

    logic       p_in;
    logic       p_q_reg;
    logic       tick;
    logic [3:0] sec_ones_reg, sec_ones_next;
    logic [3:0] sec_tens_reg, sec_tens_next;
    logic [3:0] min_ones_reg, min_ones_next;
    logic       zero_reg, zero_next;
    logic       done_reg, done_next;
    logic       decrement;

`ifdef PGT_SYNC_EN
    logic [1:0] sync_reg;

    always_ff @(posedge clk_100Hz) begin
        if (clear) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], pgt_1Hz};
        end
    end

    assign p_in = sync_reg[1];
`else
    assign p_in = pgt_1Hz;
`endif

    assign tick = p_in & ~p_q_reg;

    always_ff @(posedge clk_100Hz) begin
        if (clear) begin
            p_q_reg      <= 1'b0;
            sec_ones_reg <= 4'd0;
            sec_tens_reg <= 4'd0;
            min_ones_reg <= 4'd0;
            zero_reg     <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            p_q_reg      <= p_in;
            sec_ones_reg <= sec_ones_next;
            sec_tens_reg <= sec_tens_next;
            min_ones_reg <= min_ones_next;
            zero_reg     <= zero_next;
            done_reg     <= done_next;
        end
    end

    // Key entry takes priority over counting; out-of-range digits are dropped.
    always_comb begin
        sec_ones_next = sec_ones_reg;
        sec_tens_next = sec_tens_reg;
        min_ones_next = min_ones_reg;
        decrement     = 1'b0;
        if (tick) begin
            if (!loadn) begin
                if (bcd <= 4'd9) begin
                    min_ones_next = sec_tens_reg;
                    sec_tens_next = sec_ones_reg;
                    sec_ones_next = bcd;
                end
            end else if (count_en && !zero_reg) begin
                decrement = 1'b1;
                if (sec_ones_reg != 4'd0) begin
                    sec_ones_next = sec_ones_reg - 4'd1;
                end else begin
                    sec_ones_next = 4'd9;
                    // Non-normalised tens (6-9) count down linearly; 5 only on borrow.
                    if (sec_tens_reg != 4'd0) begin
                        sec_tens_next = sec_tens_reg - 4'd1;
                    end else begin
                        sec_tens_next = 4'd5;
                        min_ones_next = min_ones_reg - 4'd1;
                    end
                end
            end
        end
        zero_next = (sec_ones_next == 4'd0) && (sec_tens_next == 4'd0) &&
                    (min_ones_next == 4'd0);
        done_next = decrement && zero_next;
    end

    assign sec_ones = sec_ones_reg;
    assign sec_tens = sec_tens_reg;
    assign min_ones = min_ones_reg;
    assign zero     = zero_reg;
    assign done     = done_reg;

endmodule
